// File: rtl/ahb_spi_flash_pkg.sv
// Shared codes for the SPI-flash command sequencer: request op codes,
// AHB driver order codes and the sequencer state encoding.
package ahb_spi_flash_pkg;

   localparam logic [1:0] OP_RD    = 2'd0;
   localparam logic [1:0] OP_ER_WR = 2'd1;
   localparam logic [1:0] OP_ER    = 2'd2;
   localparam logic [1:0] OP_WR    = 2'd3;

   localparam logic [1:0] ORD_ER = 2'd0;
   localparam logic [1:0] ORD_WR = 2'd1;
   localparam logic [1:0] ORD_RD = 2'd2;

   localparam logic [3:0] ST_IDLE     = 4'd0;
   localparam logic [3:0] ST_WAIT_ON  = 4'd1;
   localparam logic [3:0] ST_ER_ISSUE = 4'd2;
   localparam logic [3:0] ST_ER_WAIT  = 4'd3;
   localparam logic [3:0] ST_WR_ISSUE = 4'd4;
   localparam logic [3:0] ST_WR_WAIT  = 4'd5;
   localparam logic [3:0] ST_RD_ISSUE = 4'd6;
   localparam logic [3:0] ST_RD_WAIT  = 4'd7;
   localparam logic [3:0] ST_DONE     = 4'd8;

endpackage

// File: rtl/ahb_idle_edge_det.sv
// Registers the AHB driver idle level through two flops and flags the
// cycle on which the registered level rises from 0 to 1.
module ahb_idle_edge_det
   import ahb_spi_flash_pkg::*;
(
   input  logic clk,
   input  logic rst_n,
   input  logic idle,
   output logic rise
);

   logic [1:0] sync;
   logic       last;

   // Two-flop register of the idle level plus one history flop for the edge
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync <= 2'b00;
         last <= 1'b0;
      end else begin
         sync <= {sync[0], idle};
         last <= sync[1];
      end
   end

   assign rise = sync[1] & ~last;

endmodule

// File: rtl/ahb_spi_flash_seq.sv
// SPI-flash command sequencer: accepts one read / erase+write / erase /
// write request and breaks it into aligned erase, page-bounded program and
// size-capped read commands for the AHB flash command driver, one at a time.
// Optional build macro AHB_SPI_FLASH_SEQ_TIMEOUT_EN adds a per-command
// timeout that aborts the request and raises o_err.
module ahb_spi_flash_seq #(
   parameter int ADDR_W      = 32,
   parameter int LEN_W       = 32,
   parameter int ERASE_SIZE  = 65536,
   parameter int PAGE_SIZE   = 256,
   parameter int RD_CHUNK    = 4096,
   parameter int TIMEOUT_CYC = 2**24
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_req_valid,
   output logic              o_req_ready,
   input  logic [1:0]        i_req_op,
   input  logic [ADDR_W-1:0] i_req_addr,
   input  logic [LEN_W-1:0]  i_req_len,
   output logic              o_busy,
   output logic              o_done,
   output logic              o_err,
   input  logic              i_flash_on,
   output logic              o_ahb_en,
   output logic [1:0]        o_ahb_order,
   output logic [ADDR_W-1:0] o_ahb_addrs,
   output logic [LEN_W-1:0]  o_ahb_lens,
   input  logic              i_ahb_idle
);

   import ahb_spi_flash_pkg::*;

   localparam logic [ADDR_W-1:0] ER_MASK   = ~ADDR_W'(ERASE_SIZE - 1);
   localparam logic [ADDR_W-1:0] ER_STEP   = ADDR_W'(ERASE_SIZE);
   localparam logic [ADDR_W-1:0] PAGE_MASK = ADDR_W'(PAGE_SIZE - 1);
   localparam logic [LEN_W-1:0]  PAGE_LEN  = LEN_W'(PAGE_SIZE);
   localparam logic [LEN_W-1:0]  RD_LEN    = LEN_W'(RD_CHUNK);
   localparam logic [LEN_W-1:0]  ER_LEN    = LEN_W'(ERASE_SIZE);

   logic [3:0]        state;
   logic [1:0]        op_q;
   logic [ADDR_W-1:0] cur_addr;
   logic [ADDR_W-1:0] er_addr;
   logic [ADDR_W-1:0] er_last;
   logic [LEN_W-1:0]  remaining;
   logic              er_pending;

   logic              cmd_en;
   logic [1:0]        cmd_order;
   logic [ADDR_W-1:0] cmd_addr;
   logic [LEN_W-1:0]  cmd_len;

   logic              idle_rise;
   logic              accept;
   logic              in_wait;
   logic              cmd_done;
   logic              advance;
   logic              park;
   logic              has_data;
   logic              launch;
   logic              timeout_fire;
   logic [LEN_W-1:0]  page_room;
   logic [LEN_W-1:0]  wr_chunk;
   logic [LEN_W-1:0]  rd_chunk;
   logic [LEN_W-1:0]  data_chunk;

   ahb_idle_edge_det u_idle_edge (
      .clk   (i_clk),
      .rst_n (i_rst_n),
      .idle  (i_ahb_idle),
      .rise  (idle_rise)
   );

   assign accept = (state == ST_IDLE) && i_req_valid;

   // Decide whether the next command may go out and size the next data chunk
   always_comb begin
      in_wait    = (state == ST_ER_WAIT) || (state == ST_WR_WAIT) || (state == ST_RD_WAIT);
      cmd_done   = in_wait && idle_rise;
      advance    = ((state == ST_WAIT_ON) || cmd_done) && i_flash_on;
      park       = cmd_done && !i_flash_on;
      has_data   = (op_q != OP_ER) && (remaining != '0);
      launch     = advance && (er_pending || has_data);
      page_room  = PAGE_LEN - LEN_W'(cur_addr & PAGE_MASK);
      wr_chunk   = (remaining < page_room) ? remaining : page_room;
      rd_chunk   = (remaining < RD_LEN) ? remaining : RD_LEN;
      data_chunk = (op_q == OP_RD) ? rd_chunk : wr_chunk;
   end

`ifdef AHB_SPI_FLASH_SEQ_TIMEOUT_EN
   localparam int TO_W = $clog2(TIMEOUT_CYC) + 1;

   logic [TO_W-1:0] to_cnt;
   logic            err;

   assign timeout_fire = ((state == ST_WAIT_ON) || in_wait) && !advance && !park &&
                         (to_cnt == TO_W'(TIMEOUT_CYC - 1));
   assign o_err = err;

   // Per-command age counter, restarted on every strobe, park and in IDLE;
   // it runs through the strobe cycle so an abort lands TIMEOUT_CYC after it
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         to_cnt <= '0;
      end else if ((state == ST_IDLE) || launch || park) begin
         to_cnt <= '0;
      end else begin
         to_cnt <= to_cnt + 1'b1;
      end
   end

   // Sticky abort flag, cleared when the next request is taken
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         err <= 1'b0;
      end else if (accept) begin
         err <= 1'b0;
      end else if (timeout_fire) begin
         err <= 1'b1;
      end
   end
`else
   assign timeout_fire = 1'b0;
   assign o_err        = 1'b0;
`endif

   // Main sequencer: request capture, command launch and progress tracking
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state      <= ST_IDLE;
         op_q       <= OP_RD;
         cur_addr   <= '0;
         er_addr    <= '0;
         er_last    <= '0;
         remaining  <= '0;
         er_pending <= 1'b0;
         cmd_en     <= 1'b0;
         cmd_order  <= ORD_ER;
         cmd_addr   <= '0;
         cmd_len    <= '0;
      end else begin
         cmd_en <= 1'b0;
         if (advance) begin
            if (er_pending) begin
               cmd_en     <= 1'b1;
               cmd_order  <= ORD_ER;
               cmd_addr   <= er_addr;
               cmd_len    <= ER_LEN;
               er_addr    <= er_addr + ER_STEP;
               er_pending <= (er_addr != er_last);
               state      <= ST_ER_ISSUE;
            end else if (has_data) begin
               cmd_en    <= 1'b1;
               cmd_order <= (op_q == OP_RD) ? ORD_RD : ORD_WR;
               cmd_addr  <= cur_addr;
               cmd_len   <= data_chunk;
               cur_addr  <= cur_addr + ADDR_W'(data_chunk);
               remaining <= remaining - data_chunk;
               state     <= (op_q == OP_RD) ? ST_RD_ISSUE : ST_WR_ISSUE;
            end else begin
               state <= ST_DONE;
            end
         end else if (park) begin
            state <= ST_WAIT_ON;
         end else if (timeout_fire) begin
            state <= ST_DONE;
         end else begin
            case (state)
               ST_IDLE: begin
                  if (accept) begin
                     op_q       <= i_req_op;
                     cur_addr   <= i_req_addr;
                     remaining  <= i_req_len;
                     er_addr    <= i_req_addr & ER_MASK;
                     er_last    <= (i_req_addr + ADDR_W'(i_req_len) - ADDR_W'(1)) & ER_MASK;
                     er_pending <= (i_req_op == OP_ER_WR) || (i_req_op == OP_ER);
                     state      <= (i_req_len == '0) ? ST_DONE : ST_WAIT_ON;
                  end
               end
               ST_ER_ISSUE: state <= ST_ER_WAIT;
               ST_WR_ISSUE: state <= ST_WR_WAIT;
               ST_RD_ISSUE: state <= ST_RD_WAIT;
               ST_DONE:     state <= ST_IDLE;
               default:     state <= state;
            endcase
         end
      end
   end

   assign o_req_ready = (state == ST_IDLE);
   assign o_busy      = (state != ST_IDLE);
   assign o_done      = (state == ST_DONE);
   assign o_ahb_en    = cmd_en;
   assign o_ahb_order = cmd_order;
   assign o_ahb_addrs = cmd_addr;
   assign o_ahb_lens  = cmd_len;

endmodule
